anita3_l3_phi_coincidence: RTL

ANITA3_L3_PHI_COINCIDENCE -- requirements
Module: anita3_l3_phi_coincidence

---
 rtl/anita3_l3_phi_coincidence.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/anita3_l3_phi_coincidence.sv
// ANITA-3 L3 trigger: adjacent phi-sector coincidence per polarisation, with ack handshake and dead-time accounting.
// Define ANITA3_L3_HPOL_EN to build the H-pol path; otherwise only V-pol forms triggers.
module anita3_l3_phi_coincidence #(
    parameter int NUM_PHI = 16,
    parameter int WINDOW  = 4,
    parameter int HOLDOFF = 64
) (
    input  logic               clk250_i,
    input  logic               rst_n_i,
    input  logic [NUM_PHI-1:0] V_pol_phi_i,
    input  logic [NUM_PHI-1:0] H_pol_phi_i,
    input  logic               enable_i,
    input  logic               trig_ack_i,
    output logic               trig_o,
    output logic [1:0]         trig_pol_o,
    output logic [NUM_PHI-1:0] trig_phi_o,
    output logic               holdoff_o,
    output logic [15:0]        missed_o
);

    localparam logic [3:0] WIN  = 4'(WINDOW);
    localparam logic [7:0] HOLD = 8'(HOLDOFF);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PENDING, S_HOLDOFF} state_t;

    function automatic logic [3:0] stretch_next(input logic [3:0] cnt, input logic rise,
                                                input logic en);
        if (!en)          return 4'd0;
        if (rise)         return WIN;
        if (cnt != 4'd0)  return cnt - 4'd1;
        return 4'd0;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Reset release synchroniser; assertion stays asynchronous.
    logic rst_meta, rst_sync;
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) {rst_sync, rst_meta} <= 2'b00;
        else          {rst_sync, rst_meta} <= {rst_meta, 1'b1};
    end

    // V-pol: double register, edge detect, stretch, adjacent-pair coincidence.
    logic [NUM_PHI-1:0] v_q, v_qq, v_rise, v_s, v_coinc;
    logic [3:0]         v_cnt [NUM_PHI];

    assign v_rise = v_q & ~v_qq;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v_q     <= '0;
            v_qq    <= '0;
            v_coinc <= '0;
            for (int j = 0; j < NUM_PHI; j++) v_cnt[j] <= 4'd0;
        end else begin
            v_q     <= V_pol_phi_i;
            v_qq    <= v_q;
            v_coinc <= v_s & {v_s[0], v_s[NUM_PHI-1:1]};
            for (int j = 0; j < NUM_PHI; j++)
                v_cnt[j] <= stretch_next(v_cnt[j], v_rise[j], enable_i);
        end
    end

    always_comb begin
        v_s = '0;
        for (int j = 0; j < NUM_PHI; j++) v_s[j] = (v_cnt[j] != 4'd0);
    end

    logic [NUM_PHI-1:0] h_coinc;
`ifdef ANITA3_L3_HPOL_EN
    logic [NUM_PHI-1:0] h_q, h_qq, h_rise, h_s;
    logic [3:0]         h_cnt [NUM_PHI];

    assign h_rise = h_q & ~h_qq;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q     <= '0;
            h_qq    <= '0;
            h_coinc <= '0;
            for (int j = 0; j < NUM_PHI; j++) h_cnt[j] <= 4'd0;
        end else begin
            h_q     <= H_pol_phi_i;
            h_qq    <= h_q;
            h_coinc <= h_s & {h_s[0], h_s[NUM_PHI-1:1]};
            for (int j = 0; j < NUM_PHI; j++)
                h_cnt[j] <= stretch_next(h_cnt[j], h_rise[j], enable_i);
        end
    end

    always_comb begin
        h_s = '0;
        for (int j = 0; j < NUM_PHI; j++) h_s[j] = (h_cnt[j] != 4'd0);
    end
`else
    logic unused_hpol;
    assign unused_hpol = ^H_pol_phi_i;
    assign h_coinc     = '0;
`endif

    // Trigger FSM and dead-time bookkeeping.
    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic       latch, any_coinc, any_coinc_d, coinc_rise;

    assign any_coinc  = (|v_coinc) | (|h_coinc);
    assign coinc_rise = any_coinc & ~any_coinc_d;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        latch        = 1'b0;
        if (!rst_sync) begin
            state_nxt = S_IDLE;
        end else if (!enable_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_ARMED;
                S_ARMED:   if (any_coinc) begin
                               state_nxt = S_PENDING;
                               latch     = 1'b1;
                           end
                S_PENDING: if (trig_ack_i) begin
                               state_nxt    = S_HOLDOFF;
                               hold_cnt_nxt = HOLD;
                           end
                S_HOLDOFF: if (hold_cnt == 8'd0) state_nxt = S_ARMED;
                           else hold_cnt_nxt = hold_cnt - 8'd1;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            hold_cnt    <= 8'd0;
            any_coinc_d <= 1'b0;
            trig_phi_o  <= '0;
            trig_pol_o  <= 2'b00;
            missed_o    <= 16'd0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            any_coinc_d <= any_coinc;
            if (latch) begin
                trig_phi_o <= v_coinc | h_coinc;
                trig_pol_o <= {|h_coinc, |v_coinc};
            end
            if (coinc_rise && (state == S_PENDING || state == S_HOLDOFF))
                missed_o <= sat_inc(missed_o);
        end
    end

    assign trig_o    = (state == S_PENDING);
    assign holdoff_o = (state == S_PENDING) || (state == S_HOLDOFF);

endmodule
